// File: rtl/mont_exp_pkg.sv
// rtl/mont_exp_pkg.sv - shared state encoding and parameter defaults for mont_exp
package mont_exp_pkg;

  localparam int WIDTH_DEFAULT  = 512;
  localparam int ELEN_W_DEFAULT = 10;

  typedef enum logic [3:0] {
    IDLE,
    PRE_S,
    PRE_W,
    SQR_S,
    SQR_W,
    MUL_S,
    MUL_W,
    NEXT,
    POST_S,
    POST_W,
    DONE
  } state_t;

endpackage

// File: rtl/mont_exp.sv
// rtl/mont_exp.sv - left-to-right square-and-multiply X^E mod M sequencer over a Montgomery core
// Optional MONT_EXP_CYCLE_CNT_EN adds a saturating start-to-done cycle counter output.
module mont_exp
  import mont_exp_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int ELEN_W = ELEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_e_len,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_r2,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [WIDTH-1:0]  mm_a,
  output logic [WIDTH-1:0]  mm_b,
  output logic [WIDTH-1:0]  mm_m,
  input  logic [WIDTH-1:0]  mm_result,
  input  logic              mm_done
`ifdef MONT_EXP_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  localparam int                IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]  ONE   = WIDTH'(1);
  localparam logic [ELEN_W-1:0] T_MAX = ELEN_W'(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  xt_q, xt_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  e_q, e_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  mm_a_q, mm_a_d;
  logic [WIDTH-1:0]  mm_b_q, mm_b_d;
  logic [ELEN_W-1:0] t_q, t_d;
  logic [ELEN_W-1:0] idx_q, idx_d;
  logic [ELEN_W-1:0] t_in;
  logic              e_bit;

  assign t_in  = (in_e_len > T_MAX) ? T_MAX : in_e_len;
  assign e_bit = e_q[idx_q[IDX_W-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PRE_S;
      PRE_S:   state_d = PRE_W;
      PRE_W:   if (mm_done) state_d = (t_q == '0) ? POST_S : SQR_S;
      SQR_S:   state_d = SQR_W;
      SQR_W:   if (mm_done) state_d = e_bit ? MUL_S : NEXT;
      MUL_S:   state_d = MUL_W;
      MUL_W:   if (mm_done) state_d = NEXT;
      NEXT:    state_d = (idx_q == '0) ? POST_S : SQR_S;
      POST_S:  state_d = POST_W;
      POST_W:  if (mm_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mm_start = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE:                        busy     = 1'b0;
      PRE_S, SQR_S, MUL_S, POST_S: mm_start = 1'b1;
      DONE:                        done     = 1'b1;
      default:                     ;
    endcase
  end

  // Operands are loaded on the transition into each *_S state so they are
  // already stable in the cycle mm_start is high and stay put until mm_done.
  always_comb begin
    a_d      = a_q;
    xt_d     = xt_q;
    r_d      = r_q;
    e_d      = e_q;
    m_d      = m_q;
    t_d      = t_q;
    idx_d    = idx_q;
    result_d = result_q;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d    = in_r;
          e_d    = in_e;
          m_d    = in_m;
          t_d    = t_in;
          mm_a_d = in_x;
          mm_b_d = in_r2;
        end
      end
      PRE_W: begin
        if (mm_done) begin
          xt_d   = mm_result;
          a_d    = r_q;
          idx_d  = t_q - ELEN_W'(1);
          mm_a_d = r_q;
          mm_b_d = (t_q == '0) ? ONE : r_q;
        end
      end
      SQR_W: begin
        if (mm_done) begin
          a_d = mm_result;
          if (e_bit) begin
            mm_a_d = mm_result;
            mm_b_d = xt_q;
          end
        end
      end
      MUL_W: begin
        if (mm_done) a_d = mm_result;
      end
      NEXT: begin
        mm_a_d = a_q;
        if (idx_q == '0) begin
          mm_b_d = ONE;
        end else begin
          idx_d  = idx_q - ELEN_W'(1);
          mm_b_d = a_q;
        end
      end
      POST_W: begin
        if (mm_done) result_d = mm_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      xt_q     <= '0;
      r_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
    end else begin
      a_q      <= a_d;
      xt_q     <= xt_d;
      r_q      <= r_d;
      e_q      <= e_d;
      m_q      <= m_d;
      t_q      <= t_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      mm_a_q   <= mm_a_d;
      mm_b_q   <= mm_b_d;
    end
  end

  assign result = result_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_m   = m_q;

`ifdef MONT_EXP_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && start) begin
      cyc_d = '0;
    end else if (busy && cyc_q != '1) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_cnt = cyc_q;
`endif

endmodule
